// File: rtl/seq_store_pkg.sv
// Shared types and constants for the Simon sequence store.
// Colour codes match the LED/tone driver encoding.
package seq_store_pkg;

    localparam int unsigned DEF_WORD_W = 2;
    localparam int unsigned DEF_DEPTH  = 8;

    typedef enum logic [1:0] {
        IDLE,
        PLAY,
        DONE
    } state_e;

    localparam logic [1:0] RED    = 2'd0;
    localparam logic [1:0] GREEN  = 2'd1;
    localparam logic [1:0] BLUE   = 2'd2;
    localparam logic [1:0] YELLOW = 2'd3;

endpackage

// File: rtl/seq_store_ram.sv
// DEPTH x WORD_W flop array: one synchronous write port, one registered read port
// and one combinational read port. Array contents are deliberately not reset.
module seq_store_ram
    import seq_store_pkg::*;
#(
    parameter int unsigned WORD_W = DEF_WORD_W,
    parameter int unsigned DEPTH  = DEF_DEPTH,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              we,
    input  logic [AW-1:0]     wr_addr,
    input  logic [WORD_W-1:0] wr_data,
    input  logic [AW-1:0]     rd_addr,
    output logic [WORD_W-1:0] rd_data,
    input  logic [AW-1:0]     ca_addr,
    output logic [WORD_W-1:0] ca_data
);

    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    logic [WORD_W-1:0] mem [DEPTH];

    // The top only writes at length < DEPTH, so wr_addr is always in range.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_data <= '0;
        end else if ({1'b0, rd_addr} < DEPTH_W) begin
            rd_data <= mem[rd_addr];
        end
    end

    assign ca_data = ({1'b0, ca_addr} < DEPTH_W) ? mem[ca_addr] : '0;

endmodule

// File: rtl/seq_store.sv
// Simon sequence store: append, random readback and handshaked playback.
// Optional player-input checker enabled with macro SEQ_STORE_CHECK_EN.
module seq_store
    import seq_store_pkg::*;
#(
    parameter int unsigned WORD_W = DEF_WORD_W,
    parameter int unsigned DEPTH  = DEF_DEPTH,
    localparam int unsigned AW    = $clog2(DEPTH),
    localparam int unsigned LW    = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              clear,
    input  logic              push,
    input  logic [WORD_W-1:0] push_data,
    output logic              full,
    output logic              overflow,
    output logic [LW-1:0]     length,
    input  logic [AW-1:0]     rd_addr,
    output logic [WORD_W-1:0] rd_data,
    input  logic              play_start,
    output logic              play_valid,
    output logic [WORD_W-1:0] play_data,
    input  logic              play_ready,
    output logic              play_busy,
    output logic              play_done,
    input  logic              chk_valid,
    input  logic [WORD_W-1:0] chk_data,
    output logic              chk_match,
    output logic              chk_miss,
    output logic              chk_last
);

    localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

    logic [LW-1:0]     len_q, len_d;
    logic [LW-1:0]     plen_q, plen_d;
    logic [AW-1:0]     ptr_q, ptr_d;
    state_e            state_q, state_d;
    logic              ovf_q;
    logic              we;
    logic [AW-1:0]     ca_addr;
    logic [WORD_W-1:0] ca_data;

    assign full     = (len_q == DEPTH_L);
    assign we       = push && !full && !clear;
    assign length   = len_q;
    assign overflow = ovf_q;

    seq_store_ram #(
        .WORD_W (WORD_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk     (clk),
        .resetn  (resetn),
        .we      (we),
        .wr_addr (len_q[AW-1:0]),
        .wr_data (push_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .ca_addr (ca_addr),
        .ca_data (ca_data)
    );

    always_comb begin
        len_d = len_q;
        if (clear) begin
            len_d = '0;
        end else if (we) begin
            len_d = len_q + LW'(1);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            len_q   <= '0;
            ovf_q   <= 1'b0;
            state_q <= IDLE;
            ptr_q   <= '0;
            plen_q  <= '0;
        end else begin
            len_q   <= len_d;
            ovf_q   <= push && full && !clear;
            state_q <= state_d;
            ptr_q   <= ptr_d;
            plen_q  <= plen_d;
        end
    end

    // Playback length is latched at start so appends during PLAY do not extend it.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        plen_d  = plen_q;
        if (clear) begin
            state_d = IDLE;
            ptr_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (play_start) begin
                        if (len_q != '0) begin
                            state_d = PLAY;
                            plen_d  = len_q;
                            ptr_d   = '0;
                        end else begin
                            state_d = DONE;
                        end
                    end
                end
                PLAY: begin
                    if (play_ready) begin
                        if (LW'(ptr_q) == plen_q - LW'(1)) begin
                            state_d = DONE;
                        end else begin
                            ptr_d = ptr_q + AW'(1);
                        end
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        play_valid = 1'b0;
        play_busy  = 1'b0;
        play_done  = 1'b0;
        play_data  = '0;
        if (state_q == PLAY) begin
            play_valid = 1'b1;
            play_busy  = 1'b1;
            play_data  = ca_data;
        end
        if (state_q == DONE) begin
            play_done = 1'b1;
        end
    end

`ifdef SEQ_STORE_CHECK_EN
    logic [AW-1:0] chk_ptr_q, chk_ptr_d;
    logic          match_q, match_d;
    logic          miss_q, miss_d;
    logic          last_q, last_d;

    // The combinational port is shared: player input is only meaningful outside PLAY.
    assign ca_addr = (state_q == PLAY) ? ptr_q : chk_ptr_q;

    always_comb begin
        chk_ptr_d = chk_ptr_q;
        match_d   = 1'b0;
        miss_d    = 1'b0;
        last_d    = 1'b0;
        if (clear) begin
            chk_ptr_d = '0;
        end else begin
            if (chk_valid) begin
                if (len_q == '0) begin
                    miss_d = 1'b1;
                end else if (chk_data == ca_data) begin
                    match_d = 1'b1;
                    if (LW'(chk_ptr_q) == len_q - LW'(1)) begin
                        last_d    = 1'b1;
                        chk_ptr_d = '0;
                    end else begin
                        chk_ptr_d = chk_ptr_q + AW'(1);
                    end
                end else begin
                    miss_d    = 1'b1;
                    chk_ptr_d = '0;
                end
            end
            if (state_q == DONE) begin
                chk_ptr_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            chk_ptr_q <= '0;
            match_q   <= 1'b0;
            miss_q    <= 1'b0;
            last_q    <= 1'b0;
        end else begin
            chk_ptr_q <= chk_ptr_d;
            match_q   <= match_d;
            miss_q    <= miss_d;
            last_q    <= last_d;
        end
    end

    assign chk_match = match_q;
    assign chk_miss  = miss_q;
    assign chk_last  = last_q;
`else
    logic unused_chk;

    assign ca_addr    = ptr_q;
    assign unused_chk = ^{chk_valid, chk_data};
    assign chk_match  = 1'b0;
    assign chk_miss   = 1'b0;
    assign chk_last   = 1'b0;
`endif

endmodule

// File: doc/seq_store.md
Name: seq_store

Overview:
- Parametrised sequence memory for the Simon game; successor to the fixed 8×2-bit level/colour store.
- Holds an ordered colour sequence of up to DEPTH entries, WORD_W bits each.
- Supports clocked append, random-access readback, and a handshaked playback engine that streams the sequence to the LED/tone driver.
- Sits between the game-control FSM (push/clear/play_start) and the display path (play_*).

Parameters:
- WORD_W, 2, bits per entry (colour code).
- DEPTH, 8, maximum sequence length (levels); need not be a power of two.
- AW, $clog2(DEPTH), address width (derived, not overridden).
- LW, $clog2(DEPTH+1), width of the length count (derived).

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- resetn  in  1  asynchronous active-low reset.
- clear  in  1  empties the sequence: length:=0, playback aborted.
- push  in  1  append push_data at index length when not full.
- push_data  in  WORD_W  entry to append.
- full  out  1  length==DEPTH.
- overflow  out  1  one-cycle pulse: push while full.
- length  out  LW  number of valid entries.
- rd_addr  in  AW  random-access read address.
- rd_data  out  WORD_W  mem[rd_addr], registered (1-cycle latency).
- play_start  in  1  begin playback; sampled only in IDLE.
- play_valid  out  1  play_data is valid.
- play_data  out  WORD_W  current playback entry.
- play_ready  in  1  consumer accepts play_data.
- play_busy  out  1  FSM is in PLAY.
- play_done  out  1  one-cycle pulse at end of playback.
- chk_valid  in  1  player input strobe (optional feature).
- chk_data  in  WORD_W  player colour (optional feature).
- chk_match  out  1  player input matched expected entry (optional feature).
- chk_miss  out  1  player input did not match (optional feature).
- chk_last  out  1  matched the final entry (optional feature).

Behaviour:
- Reset (resetn=0, asynchronous): length=0, rd_data=0, FSM=IDLE, play_ptr=0. All outputs 0. Memory array contents are NOT reset.
- Append:
  - push && !full: mem[length]:=push_data and length+1, both on the same edge.
  - push && full: no write; overflow=1 for one cycle.
- Priority: clear beats push in the same cycle. clear wins; the entry is dropped.
- rd_data: registered every cycle. Reading an address >= length returns stale array content; no error is flagged.
- FSM states:
  - IDLE:
    - play_start && length>0: latch plen:=length, play_ptr:=0, go to PLAY.
    - play_start && length==0: go to DONE.
  - PLAY: play_valid=1, play_data=mem[play_ptr] (combinational from the array).
    - A transfer occurs on play_valid && play_ready.
    - On transfer with play_ptr==plen-1: go to DONE.
    - On any other transfer: play_ptr+1.
    - No transfer: hold play_ptr and play_data stable.
  - DONE: play_done=1 for exactly one cycle, then go to IDLE.
- play_busy=1 only in PLAY.
- Appends during PLAY are accepted; plen is not affected, so playback ends at the length latched at start.
- play_start outside IDLE is ignored.
- clear during PLAY or DONE: go to IDLE immediately, with no play_done pulse.

Optional Feature:
- Macro: SEQ_STORE_CHECK_EN.
- Defined:
  - chk_ptr (AW bits) resets to 0 on resetn, clear, play_done, and on a miss.
  - On chk_valid, compare chk_data with mem[chk_ptr], then:
    - Equal: chk_match=1 the next cycle and chk_ptr+1. If chk_ptr==length-1, also chk_last=1 and chk_ptr:=0.
    - Not equal: chk_miss=1 the next cycle.
  - chk_valid with length==0 produces chk_miss.
- Undefined:
  - chk_match, chk_miss and chk_last are tied to 0.
  - chk_valid and chk_data are ignored.
  - No chk_ptr logic is present.
  - The port list is unchanged in both builds.

Decomposition:
- Package seq_store_pkg:
  - state enum {IDLE, PLAY, DONE}.
  - Default WORD_W and DEPTH constants.
  - Colour code constants (RED, GREEN, BLUE, YELLOW = 0..3).
- Sub-module seq_store_ram:
  - DEPTH×WORD_W flop array.
  - One synchronous write port.
  - One registered read port (rd_data).
  - One combinational read port (playback/check).
- The top level holds the length counter, FSM and check logic.

Test Plan:
- Reset, push 3,1,2, rd_addr=1 -> rd_data=1 one cycle later; length=3; full=0.
- Push 9 entries with DEPTH=8 -> full=1 after the 8th; 9th gives overflow pulse; length stays 8; mem[7] unchanged.
- Length=3, play_start with play_ready stuck low 4 cycles then high -> play_valid=1, data 3 held; then 3,1,2 on consecutive cycles; play_done pulse on the cycle after the last transfer.
- play_start with length=0 -> no play_valid; play_done pulses once, 1 cycle later. clear mid-PLAY -> play_busy drops next cycle; no play_done.
- Push during PLAY (length 3→4) -> playback still emits exactly 3 entries; subsequent play emits 4.
- SEQ_STORE_CHECK_EN, sequence 3,1,2: chk inputs 3,1,2 -> match, match, match+chk_last. Then 3,0 -> match, miss; chk_ptr back to 0.
